asmi_reply_tx: RTL and testbench
================================

ASMI_REPLY_TX -- requirements
Module: asmi_reply_tx

Interface
REQ-001 Parameter: FRAME_LEN, 60, total reply frame length in bytes (legal 8..255).
REQ-002 Parameter: CODE_ERASE, 8'h01, status byte for erase-complete reply.
REQ-003 Parameter: CODE_MORE, 8'h02, status byte for send-more/final-block reply.
REQ-004 Port: clock  in  1  single clock, all logic on rising edge.
REQ-005 Port: reset_n  in  1  asynchronous active-low reset.
REQ-006 Port: erase_done  in  1  level request from flash programmer: erase complete.
REQ-007 Port: send_more  in  1  level request from flash programmer: page written, send next block.
REQ-008 Port: checksum  in  16  running image checksum from flash programmer.
REQ-009 Port: erase_done_ACK  out  1  acknowledge for erase_done.
REQ-010 Port: send_more_ACK  out  1  acknowledge for send_more.
REQ-011 Port: tx_req  out  1  request for the shared Ethernet Tx path.
REQ-012 Port: tx_grant  in  1  Tx arbiter grant, level, valid while tx_req high.
REQ-013 Port: tx_data  out  8  reply frame byte.
REQ-014 Port: tx_valid  out  1  tx_data valid.
REQ-015 Port: tx_ready  in  1  Tx path accepts byte when tx_valid and tx_ready both high.
REQ-016 Port: tx_last  out  1  high with final byte (index FRAME_LEN-1).
REQ-017 Port: seq_num  out  32  sequence number of the next frame to send.

Function
REQ-018 Both request inputs SHALL pass through a two-flop synchroniser before use; ACK latency counted from synchronised level.
REQ-019 State machine SHALL have states IDLE, REQ, SEND, ACK.
REQ-020 IDLE: on synchronised erase_done or send_more high, SHALL latch type (erase_done wins if both high same cycle), latch checksum, go to REQ.
REQ-021 REQ: tx_req SHALL be high; on tx_grant high go to SEND with byte index 0.
REQ-022 SEND: tx_req and tx_valid high; index advances only on tx_valid&tx_ready; tx_data held stable otherwise.
REQ-023 Frame layout: bytes 0-3 seq_num big-endian; byte 4 status code; bytes 5-6 latched checksum big-endian; bytes 7..FRAME_LEN-1 = 8'h00.
REQ-024 On acceptance of byte FRAME_LEN-1: tx_valid, tx_last, tx_req low next cycle; seq_num increments by 1 (wraps 32'hFFFFFFFF -> 0); go to ACK.
REQ-025 ACK: SHALL drive the ACK matching the latched type high; hold until that synchronised request is low, then drop ACK and return to IDLE.
REQ-026 Other request arriving during REQ/SEND/ACK SHALL be held pending (level) and serviced from IDLE; no request is lost or merged.
REQ-027 tx_grant dropping during SEND SHALL NOT abort the frame; block completes frame when tx_ready allows.
REQ-028 ACK outputs SHALL never both be high; an ACK SHALL never assert before its frame's last byte is accepted.
REQ-029 Checksum changes after latch SHALL NOT alter the frame in flight.

Reset
REQ-030 reset_n low SHALL asynchronously force state IDLE, all outputs 0, seq_num 0, synchronisers and latched fields 0.
REQ-031 Reset mid-frame SHALL abandon the frame; no ACK issued; seq_num returns to 0.
REQ-032 After reset release, a request already high SHALL be serviced normally (new frame, seq 0).

Verification
REQ-033 reset; checksum=16'hA55A; pulse send_more high, tx_grant=1, tx_ready=1 -> 60 bytes 00 00 00 00 02 A5 5A 00.., tx_last on byte 59, send_more_ACK high until send_more low, seq_num=1.
REQ-034 erase_done and send_more rise same cycle -> first frame code 01 with erase_done_ACK, then second frame code 02 seq 1 with send_more_ACK.
REQ-035 tx_ready toggled randomly 50% -> byte sequence identical to REQ-033, tx_data stable while tx_valid&!tx_ready.
REQ-036 tx_grant delayed 100 cycles -> tx_valid stays 0, tx_req 1 throughout; frame then sent intact.
REQ-037 Force seq_num path to 32'hFFFFFFFF (send via preload sequence) -> frame bytes FF FF FF FF, seq_num becomes 0.
REQ-038 reset_n low at byte 30 -> outputs 0 immediately, no ACK; after release with send_more still high -> full frame seq 0.

Source files
------------

// File: rtl/asmi_reply_tx.sv
// asmi_reply_tx: builds and transmits the fixed-length reply frame that tells the
// host an erase has finished or that the next image block may be sent. It
// requests the shared Ethernet Tx path, streams the frame, and then acknowledges
// the flash programmer's level request once the last byte is accepted.
module asmi_reply_tx #(
   parameter int unsigned FRAME_LEN  = 60,
   parameter logic [7:0]  CODE_ERASE = 8'h01,
   parameter logic [7:0]  CODE_MORE  = 8'h02
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        erase_done,
   input  logic        send_more,
   input  logic [15:0] checksum,
   output logic        erase_done_ACK,
   output logic        send_more_ACK,
   output logic        tx_req,
   input  logic        tx_grant,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        tx_last,
   output logic [31:0] seq_num
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      SEND = 2'd2,
      ACK  = 2'd3
   } state_t;

   localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

   state_t      state;
   logic        erase_s1, erase_s2;
   logic        more_s1, more_s2;
   logic        is_erase;
   logic [15:0] csum_q;
   logic [7:0]  idx;
   logic [31:0] seq_q;
   logic [7:0]  status_code;
   logic [7:0]  next_idx;
   logic        req_still;

   // Header bytes: sequence number and checksum big-endian, zero padding after.
   function automatic logic [7:0] frame_byte(input logic [7:0]  i,
                                             input logic [31:0] seq,
                                             input logic [7:0]  code,
                                             input logic [15:0] cs);
      logic [7:0] b;
      case (i)
         8'd0:    b = seq[31:24];
         8'd1:    b = seq[23:16];
         8'd2:    b = seq[15:8];
         8'd3:    b = seq[7:0];
         8'd4:    b = code;
         8'd5:    b = cs[15:8];
         8'd6:    b = cs[7:0];
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   assign status_code = is_erase ? CODE_ERASE : CODE_MORE;
   assign next_idx    = idx + 8'd1;
   // The request being acknowledged; the other one stays pending as a level.
   assign req_still   = is_erase ? erase_s2 : more_s2;
   assign seq_num     = seq_q;

   // Two-flop synchronisers for the programmer's request levels.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         erase_s1 <= 1'b0;
         erase_s2 <= 1'b0;
         more_s1  <= 1'b0;
         more_s2  <= 1'b0;
      end else begin
         erase_s1 <= erase_done;
         erase_s2 <= erase_s1;
         more_s1  <= send_more;
         more_s2  <= more_s1;
      end
   end

   // Reply FSM with registered Tx handshake, ACK outputs and sequence counter.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         is_erase       <= 1'b0;
         csum_q         <= 16'h0000;
         idx            <= 8'd0;
         seq_q          <= 32'd0;
         tx_req         <= 1'b0;
         tx_valid       <= 1'b0;
         tx_last        <= 1'b0;
         tx_data        <= 8'h00;
         erase_done_ACK <= 1'b0;
         send_more_ACK  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (erase_s2 || more_s2) begin
                  // Erase wins a tie; send_more stays pending and is served next.
                  is_erase <= erase_s2;
                  csum_q   <= checksum;
                  tx_req   <= 1'b1;
                  state    <= REQ;
               end
            end
            REQ: begin
               if (tx_grant) begin
                  idx      <= 8'd0;
                  tx_valid <= 1'b1;
                  tx_last  <= 1'b0;
                  tx_data  <= frame_byte(8'd0, seq_q, status_code, csum_q);
                  state    <= SEND;
               end
            end
            SEND: begin
               // Once granted, the frame runs to completion regardless of tx_grant.
               if (tx_valid && tx_ready) begin
                  if (idx == LAST_IDX) begin
                     tx_valid <= 1'b0;
                     tx_last  <= 1'b0;
                     tx_req   <= 1'b0;
                     seq_q    <= seq_q + 32'd1;
                     if (is_erase) begin
                        erase_done_ACK <= 1'b1;
                     end else begin
                        send_more_ACK  <= 1'b1;
                     end
                     state <= ACK;
                  end else begin
                     idx     <= next_idx;
                     tx_data <= frame_byte(next_idx, seq_q, status_code, csum_q);
                     tx_last <= (next_idx == LAST_IDX);
                  end
               end
            end
            ACK: begin
               if (!req_still) begin
                  erase_done_ACK <= 1'b0;
                  send_more_ACK  <= 1'b0;
                  state          <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_asmi_reply_tx.sv
// Self-checking bench for asmi_reply_tx: a frame-level reference model checked
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_asmi_reply_tx;

   localparam int         FRAME_LEN  = 60;
   localparam logic [7:0] CODE_ERASE = 8'h01;
   localparam logic [7:0] CODE_MORE  = 8'h02;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        erase_done = 1'b0;
   logic        send_more = 1'b0;
   logic [15:0] checksum = 16'h0000;
   logic        erase_done_ACK;
   logic        send_more_ACK;
   logic        tx_req;
   logic        tx_grant = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic        tx_last;
   logic [31:0] seq_num;

   asmi_reply_tx #(
      .FRAME_LEN (FRAME_LEN),
      .CODE_ERASE(CODE_ERASE),
      .CODE_MORE (CODE_MORE)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .erase_done    (erase_done),
      .send_more     (send_more),
      .checksum      (checksum),
      .erase_done_ACK(erase_done_ACK),
      .send_more_ACK (send_more_ACK),
      .tx_req        (tx_req),
      .tx_grant      (tx_grant),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .tx_last       (tx_last),
      .seq_num       (seq_num)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [7:0]  code;
      logic [15:0] csum;
   } desc_t;

   desc_t       exp_q[$];
   desc_t       cur;
   int          n_chk = 0;
   int          n_fail = 0;
   logic [31:0] m_seq = 32'd0;
   int          bidx = 0;
   bit          in_frame = 1'b0;
   logic [7:0]  ack_code = 8'h00;
   bit          ack_first = 1'b0;
   bit          prev_stall = 1'b0;
   logic [7:0]  prev_data = 8'h00;
   bit          rand_ready = 1'b0;
   logic [7:0]  cap [0:255];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   // Reply content from the frame-layout rule: 7-byte header, then zeros.
   function automatic logic [7:0] model_byte(input logic [31:0] s, input logic [7:0] c,
                                             input logic [15:0] k, input int i);
      logic [55:0] hdr;
      hdr = {s, c, k};
      if (i < 7) return hdr[8*(6-i) +: 8];
      return 8'h00;
   endfunction

   // Frame-level reference checker, sampled on the falling edge.
   task automatic mon_loop();
      forever begin
         @(negedge clock);
         if (!reset_n) begin
            chk("rst_outputs", 64'({tx_req, tx_valid, tx_last, erase_done_ACK, send_more_ACK, tx_data}), 64'd0);
            chk("rst_seq", 64'(seq_num), 64'd0);
            m_seq = 32'd0; in_frame = 1'b0; bidx = 0;
            ack_code = 8'h00; ack_first = 1'b0; prev_stall = 1'b0;
         end else begin
            chk("seq_num", 64'(seq_num), 64'(m_seq));
            chk("ack_exclusive", 64'(erase_done_ACK & send_more_ACK), 64'd0);
            if (ack_first) begin
               chk("ack_rise", 64'({erase_done_ACK, send_more_ACK}),
                   (ack_code == CODE_ERASE) ? 64'd2 : 64'd1);
               ack_first = 1'b0;
            end else if (ack_code != 8'h00) begin
               if (!erase_done_ACK && !send_more_ACK) ack_code = 8'h00;
               else chk("ack_type", 64'({erase_done_ACK, send_more_ACK}),
                        (ack_code == CODE_ERASE) ? 64'd2 : 64'd1);
            end else begin
               chk("ack_early", 64'({erase_done_ACK, send_more_ACK}), 64'd0);
            end
            if (prev_stall) begin
               chk("stall_valid", 64'(tx_valid), 64'd1);
               chk("stall_data", 64'(tx_data), 64'(prev_data));
            end
            if (tx_valid) begin
               if (!in_frame) begin
                  if (exp_q.size() == 0) begin
                     n_chk++; n_fail++;
                     $display("FAIL unexpected_frame: got frame start, expected none");
                     cur.code = 8'h00; cur.csum = 16'h0000;
                  end else begin
                     cur = exp_q.pop_front();
                  end
                  in_frame = 1'b1;
               end
               chk("req_with_valid", 64'(tx_req), 64'd1);
               chk("tx_data", 64'(tx_data), 64'(model_byte(m_seq, cur.code, cur.csum, bidx)));
               chk("tx_last", 64'(tx_last), 64'(bidx == FRAME_LEN - 1));
               cap[bidx] = tx_data;
               prev_stall = !tx_ready;
               prev_data  = tx_data;
               if (tx_ready) begin
                  bidx++;
                  if (bidx == FRAME_LEN) begin
                     bidx = 0; in_frame = 1'b0;
                     m_seq = m_seq + 32'd1;
                     ack_code = cur.code; ack_first = 1'b1;
                  end
               end
            end else begin
               chk("last_without_valid", 64'(tx_last), 64'd0);
               prev_stall = 1'b0;
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
   endtask

   function automatic logic get_sig(input int sel);
      case (sel)
         0:       return erase_done_ACK;
         1:       return send_more_ACK;
         2:       return tx_req;
         default: return tx_valid;
      endcase
   endfunction

   task automatic wait_sig(input int sel, input logic lvl, input int bound, input string nm);
      int n = 0;
      while (get_sig(sel) !== lvl && n < bound) begin
         step();
         n++;
      end
      if (n >= bound) begin
         n_chk++; n_fail++;
         $display("FAIL timeout_%s: level %0b not seen within %0d cycles", nm, lvl, bound);
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (3) step();
      reset_n = 1'b1;
      step();
   endtask

   task automatic push(input logic [7:0] c, input logic [15:0] k);
      desc_t d;
      d.code = c; d.csum = k;
      exp_q.push_back(d);
   endtask

   task automatic stim();
      int n;
      // Reset state
      do_reset();
      chk("reset_tx_req", 64'(tx_req), 64'd0);
      chk("reset_seq", 64'(seq_num), 64'd0);

      // Single send_more reply, checksum changed while frame is in flight
      checksum = 16'hA55A; tx_grant = 1'b1; tx_ready = 1'b1;
      push(CODE_MORE, 16'hA55A);
      send_more = 1'b1;
      wait_sig(3, 1'b1, 50, "t1_valid");
      checksum = 16'h1234;
      wait_sig(1, 1'b1, 200, "t1_ack");
      chk("t1_seq_bytes", 64'({cap[0], cap[1], cap[2], cap[3]}), 64'h0);
      chk("t1_code", 64'(cap[4]), 64'h02);
      chk("t1_csum", 64'({cap[5], cap[6]}), 64'hA55A);
      chk("t1_pad", 64'({cap[7], cap[59]}), 64'h0);
      repeat (3) step();
      chk("t1_ack_hold", 64'(send_more_ACK), 64'd1);
      send_more = 1'b0;
      wait_sig(1, 1'b0, 20, "t1_ack_drop");
      chk("t1_seq_after", 64'(seq_num), 64'd1);

      // Simultaneous requests: erase first, then send_more
      do_reset();
      checksum = 16'hBEEF;
      push(CODE_ERASE, 16'hBEEF);
      push(CODE_MORE, 16'hBEEF);
      erase_done = 1'b1; send_more = 1'b1;
      wait_sig(0, 1'b1, 200, "t2_erase_ack");
      chk("t2_first_code", 64'(cap[4]), 64'h01);
      chk("t2_first_seq", 64'(cap[3]), 64'h00);
      chk("t2_no_more_ack", 64'(send_more_ACK), 64'd0);
      erase_done = 1'b0;
      wait_sig(1, 1'b1, 300, "t2_more_ack");
      chk("t2_second_code", 64'(cap[4]), 64'h02);
      chk("t2_second_seq", 64'(cap[3]), 64'h01);
      chk("t2_second_csum", 64'(cap[5]), 64'hBE);
      send_more = 1'b0;
      wait_sig(1, 1'b0, 20, "t2_ack_drop");

      // Random back-pressure, same frame content as the first reply
      do_reset();
      checksum = 16'hA55A;
      push(CODE_MORE, 16'hA55A);
      rand_ready = 1'b1;
      send_more = 1'b1;
      wait_sig(1, 1'b1, 1000, "t3_ack");
      rand_ready = 1'b0; tx_ready = 1'b1;
      chk("t3_header", 64'({cap[0], cap[1], cap[2], cap[3], cap[4], cap[5], cap[6], cap[7]}),
          64'h00000000_02A55A00);
      send_more = 1'b0;
      wait_sig(1, 1'b0, 20, "t3_ack_drop");

      // Grant held off for 100 cycles, then withdrawn mid-frame
      checksum = 16'h0F0F; tx_grant = 1'b0;
      push(CODE_MORE, 16'h0F0F);
      send_more = 1'b1;
      wait_sig(2, 1'b1, 20, "t4_req");
      for (int i = 0; i < 100; i++) begin
         step();
         chk("t4_valid_low", 64'(tx_valid), 64'd0);
         chk("t4_req_high", 64'(tx_req), 64'd1);
      end
      tx_grant = 1'b1;
      wait_sig(3, 1'b1, 10, "t4_valid");
      tx_grant = 1'b0;
      wait_sig(1, 1'b1, 200, "t4_ack");
      chk("t4_seq_byte", 64'(cap[3]), 64'h01);
      send_more = 1'b0;
      wait_sig(1, 1'b0, 20, "t4_ack_drop");
      chk("t4_seq_after", 64'(seq_num), 64'd2);

      // Sequence number preloaded to all-ones wraps to zero
      force dut.seq_q = 32'hFFFF_FFFF;
      m_seq = 32'hFFFF_FFFF;
      step();
      release dut.seq_q;
      tx_grant = 1'b1;
      push(CODE_MORE, 16'h0F0F);
      send_more = 1'b1;
      wait_sig(1, 1'b1, 200, "t5_ack");
      chk("t5_seq_bytes", 64'({cap[0], cap[1], cap[2], cap[3]}), 64'hFFFF_FFFF);
      chk("t5_seq_wrap", 64'(seq_num), 64'd0);
      send_more = 1'b0;
      wait_sig(1, 1'b0, 20, "t5_ack_drop");

      // Reset in the middle of a frame, request still high afterwards
      checksum = 16'h7E81;
      push(CODE_MORE, 16'h7E81);
      send_more = 1'b1;
      n = 0;
      while (bidx < 30 && n < 200) begin
         step();
         n++;
      end
      if (n >= 200) begin
         n_chk++; n_fail++;
         $display("FAIL timeout_t6_byte30: byte index %0d, required 30", bidx);
      end
      reset_n = 1'b0;
      #1;
      chk("t6_async_outputs", 64'({tx_req, tx_valid, tx_last, erase_done_ACK, send_more_ACK, tx_data}), 64'd0);
      chk("t6_async_seq", 64'(seq_num), 64'd0);
      repeat (3) step();
      push(CODE_MORE, 16'h7E81);
      reset_n = 1'b1;
      wait_sig(1, 1'b1, 200, "t6_ack");
      chk("t6_seq_bytes", 64'({cap[0], cap[1], cap[2], cap[3]}), 64'h0);
      chk("t6_csum", 64'({cap[5], cap[6]}), 64'h7E81);
      send_more = 1'b0;
      wait_sig(1, 1'b0, 20, "t6_ack_drop");
      chk("t6_seq_after", 64'(seq_num), 64'd1);
      chk("exp_queue_empty", 64'(exp_q.size()), 64'd0);
      repeat (3) step();
   endtask

   initial begin
      fork
         mon_loop();
         stim();
      join_any
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
